ahb_decoder: RTL and testbench

AHB-Lite address-phase decoder with an integrated default slave, sitting between the bus master and the two AHB-Lite slaves. It generates per-slave HSEL from HADDR and registers the data-phase select that steers the response `Multiplexer` (`muxSelect`). Transfers to unmapped addresses are terminated with a two-cycle ERROR response, and those errors are counted for debug.

---
 rtl/ahb_decoder.sv | 104 ++++++++++
 tb/tb_ahb_decoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_decoder.sv
// AHB-Lite address decoder for two slaves, with a default slave that ERRORs unmapped transfers.
// Latency: HSEL is combinational; muxSelect/defaultSel follow one HCLK after an accepted address phase.
// Backpressure: data-phase selects hold while HREADY is low; each error inserts exactly one wait state.
module ahb_decoder #(
    parameter logic [31:0] BASE_1 = 32'h0000_0000,
    parameter logic [31:0] MASK_1 = 32'hFFFF_F000,
    parameter logic [31:0] BASE_2 = 32'h0000_1000,
    parameter logic [31:0] MASK_2 = 32'hFFFF_F000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY,
    output logic        HSEL_1,
    output logic        HSEL_2,
    output logic        muxSelect,
    output logic        defaultSel,
    output logic        HREADYOUT_DEF,
    output logic        HRESP_DEF,
    output logic [7:0]  errCount
);

    typedef enum logic [1:0] {
        DEF_IDLE = 2'd0,
        DEF_ERR1 = 2'd1,
        DEF_ERR2 = 2'd2
    } def_state_t;

    logic       match_1;
    logic       match_2;
    logic       unmapped;
    logic       trans_active;
    logic       err_start;
    logic       cnt_inc;
    def_state_t state_q;
    def_state_t state_d;

    // Slave 1 wins on overlapping windows.
    assign match_1      = ((HADDR & MASK_1) == BASE_1);
    assign match_2      = ((HADDR & MASK_2) == BASE_2);
    assign HSEL_1       = match_1;
    assign HSEL_2       = match_2 & ~match_1;
    assign unmapped     = ~match_1 & ~match_2;

    // Only NONSEQ/SEQ are real transfers; IDLE/BUSY to a hole get a zero-wait OKAY.
    assign trans_active = (HTRANS == 2'b10) | (HTRANS == 2'b11);
    assign err_start    = unmapped & HREADY & trans_active;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            muxSelect  <= 1'b0;
            defaultSel <= 1'b0;
        end else if (HREADY) begin
            muxSelect  <= HSEL_2;
            defaultSel <= unmapped;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= DEF_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        HREADYOUT_DEF = 1'b1;
        HRESP_DEF     = 1'b0;
        cnt_inc       = 1'b0;
        case (state_q)
            DEF_IDLE: begin
                if (err_start) begin
                    state_d = DEF_ERR1;
                end
            end
            DEF_ERR1: begin
                HREADYOUT_DEF = 1'b0;
                HRESP_DEF     = 1'b1;
                cnt_inc       = 1'b1;
                state_d       = DEF_ERR2;
            end
            DEF_ERR2: begin
                HRESP_DEF = 1'b1;
                // The next address is sampled here, so errors can run back to back.
                state_d   = err_start ? DEF_ERR1 : DEF_IDLE;
            end
            default: begin
                state_d = DEF_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            errCount <= 8'h00;
        end else if (cnt_inc && (errCount != 8'hFF)) begin
            errCount <= errCount + 8'd1;
        end
    end

endmodule

// File: tb/tb_ahb_decoder.sv
// Bench for ahb_decoder: decode table, hand sequences for error/reset corners, then random traffic vs a response-queue model.
module tb_ahb_decoder;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic        HSEL_1, HSEL_2, muxSelect, defaultSel, HREADYOUT_DEF, HRESP_DEF;
    logic [7:0]  errCount;
    logic        ov_hsel_1, ov_hsel_2, ov_mux, ov_def, ov_rdy, ov_resp;
    logic [7:0]  ov_cnt;

    int n_vec;
    int n_miss;

    ahb_decoder dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HREADY(HREADY),
        .HSEL_1(HSEL_1), .HSEL_2(HSEL_2), .muxSelect(muxSelect), .defaultSel(defaultSel),
        .HREADYOUT_DEF(HREADYOUT_DEF), .HRESP_DEF(HRESP_DEF), .errCount(errCount)
    );

    ahb_decoder #(
        .BASE_1(32'h0000_0000), .MASK_1(32'hFFFF_F000),
        .BASE_2(32'h0000_0000), .MASK_2(32'hFFFF_F000)
    ) dut_ov (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HREADY(HREADY),
        .HSEL_1(ov_hsel_1), .HSEL_2(ov_hsel_2), .muxSelect(ov_mux), .defaultSel(ov_def),
        .HREADYOUT_DEF(ov_rdy), .HRESP_DEF(ov_resp), .errCount(ov_cnt)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic        hready;
        logic        e_hsel1;
        logic        e_hsel2;
        logic        e_mux;
        logic        e_def;
    } vec_t;

    vec_t tv [10];

    // Random-phase reference: queue of pending {ready, resp} data-phase responses.
    logic [1:0]  rsp_q [$];
    logic [1:0]  cur_rsp;
    logic [1:0]  popped;
    logic        exp_mux, exp_def, in1, in2, unm;
    int          exp_cnt;
    logic [31:0] r_addr;
    logic [1:0]  r_trans;
    logic        r_ready;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic r);
        HADDR  = a;
        HTRANS = t;
        HREADY = r;
        #1;
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk_def(input string nm, input logic rdy, input logic resp);
        chk({nm, "_rdy"}, HREADYOUT_DEF, rdy);
        chk({nm, "_resp"}, HRESP_DEF, resp);
    endtask

    initial begin
        n_vec   = 0;
        n_miss  = 0;
        HRESETn = 1'b1;
        HADDR   = 32'h0;
        HTRANS  = 2'd0;
        HREADY  = 1'b1;
        #3 HRESETn = 1'b0;
        cyc();
        cyc();
        chk("rst_mux", muxSelect, 1'b0);
        chk("rst_def", defaultSel, 1'b0);
        chk_def("rst", 1'b1, 1'b0);
        chk("rst_cnt", errCount, 8'h00);
        @(negedge HCLK);
        HRESETn = 1'b1;
        cyc();

        // Decode table: mapped transfers, unmapped IDLE/BUSY, and a HREADY=0 hold.
        tv[0] = '{32'h0000_0010, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[1] = '{32'h0000_1004, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[2] = '{32'h0000_0FFC, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[3] = '{32'h0000_1FFC, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[4] = '{32'h0000_8000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[5] = '{32'h0000_2000, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[6] = '{32'hFFFF_F000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[7] = '{32'h0000_1000, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[8] = '{32'h0000_0000, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[9] = '{32'h0000_0004, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive(tv[i].haddr, tv[i].htrans, tv[i].hready);
            chk("tbl_hsel1", HSEL_1, tv[i].e_hsel1);
            chk("tbl_hsel2", HSEL_2, tv[i].e_hsel2);
            cyc();
            chk("tbl_mux", muxSelect, tv[i].e_mux);
            chk("tbl_def", defaultSel, tv[i].e_def);
            chk_def("tbl", 1'b1, 1'b0);
            chk("tbl_cnt", errCount, 8'h00);
        end

        // Wait-state hold: muxSelect stays 1 through three HREADY-low cycles.
        drive(32'h0000_1004, 2'd2, 1'b1);
        cyc();
        chk("hold_set", muxSelect, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(32'h0000_0010, 2'd2, 1'b0);
            cyc();
            chk("hold_mux", muxSelect, 1'b1);
        end
        drive(32'h0000_0010, 2'd2, 1'b1);
        cyc();
        chk("hold_rel", muxSelect, 1'b0);

        // Single unmapped NONSEQ.
        drive(32'h0000_8000, 2'd2, 1'b1);
        cyc();
        chk("err_def", defaultSel, 1'b1);
        chk_def("err1", 1'b0, 1'b1);
        drive(32'h0000_8000, 2'd2, 1'b0);
        cyc();
        chk_def("err2", 1'b1, 1'b1);
        chk("err_cnt", errCount, 8'h01);
        drive(32'h0000_0010, 2'd0, 1'b1);
        cyc();
        chk_def("err_idle", 1'b1, 1'b0);
        chk("err_def0", defaultSel, 1'b0);
        chk("err_cnt1", errCount, 8'h01);

        // Back-to-back unmapped SEQ transfers with no IDLE between.
        drive(32'h0000_8004, 2'd3, 1'b1);
        cyc();
        chk_def("b2b_e1a", 1'b0, 1'b1);
        drive(32'h0000_8004, 2'd3, 1'b0);
        cyc();
        chk_def("b2b_e2a", 1'b1, 1'b1);
        chk("b2b_cnt2", errCount, 8'h02);
        drive(32'h0000_8008, 2'd3, 1'b1);
        cyc();
        chk_def("b2b_e1b", 1'b0, 1'b1);
        drive(32'h0000_8008, 2'd3, 1'b0);
        cyc();
        chk_def("b2b_e2b", 1'b1, 1'b1);
        chk("b2b_cnt3", errCount, 8'h03);
        drive(32'h0000_8000, 2'd0, 1'b1);
        cyc();
        chk_def("unm_idle", 1'b1, 1'b0);
        chk("unm_idle_def", defaultSel, 1'b1);
        drive(32'h0000_9000, 2'd1, 1'b1);
        cyc();
        chk_def("unm_busy", 1'b1, 1'b0);
        chk("unm_cnt", errCount, 8'h03);

        // Asynchronous reset in the middle of ERR1.
        drive(32'h0000_8000, 2'd2, 1'b1);
        cyc();
        chk_def("pre_rst", 1'b0, 1'b1);
        drive(32'h0000_8000, 2'd2, 1'b0);
        #1 HRESETn = 1'b0;
        #1;
        chk("arst_mux", muxSelect, 1'b0);
        chk("arst_def", defaultSel, 1'b0);
        chk_def("arst", 1'b1, 1'b0);
        chk("arst_cnt", errCount, 8'h00);
        drive(32'h0000_0000, 2'd0, 1'b1);
        @(negedge HCLK);
        HRESETn = 1'b1;
        cyc();

        // Saturation over 300 back-to-back errors.
        for (int i = 0; i < 300; i++) begin
            drive(32'h0001_0000, 2'd2, 1'b1);
            cyc();
            drive(32'h0001_0000, 2'd2, 1'b0);
            cyc();
            if (i == 99) chk("sat_100", errCount, 8'd100);
        end
        chk("sat_ff", errCount, 8'hFF);

        // Overlapping windows: slave 1 has priority.
        drive(32'h0000_0010, 2'd2, 1'b1);
        chk("ov_hsel1", ov_hsel_1, 1'b1);
        chk("ov_hsel2", ov_hsel_2, 1'b0);
        drive(32'h0000_1004, 2'd2, 1'b0);
        chk("ov_miss1", ov_hsel_1, 1'b0);
        chk("ov_miss2", ov_hsel_2, 1'b0);

        // Random traffic against the response-queue model.
        drive(32'h0000_0000, 2'd0, 1'b1);
        HRESETn = 1'b0;
        cyc();
        @(negedge HCLK);
        HRESETn = 1'b1;
        cyc();
        rsp_q.delete();
        exp_mux = 1'b0;
        exp_def = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: r_addr = $urandom_range(0, 32'h0000_0FFF);
                1: r_addr = 32'h0000_1000 + $urandom_range(0, 32'h0000_0FFF);
                default: r_addr = $urandom;
            endcase
            r_trans = 2'($urandom_range(0, 3));
            r_ready = ($urandom_range(0, 3) != 0);
            drive(r_addr, r_trans, r_ready);
            in1 = (r_addr < 32'h0000_1000);
            in2 = (r_addr >= 32'h0000_1000) && (r_addr < 32'h0000_2000);
            unm = !in1 && !in2;
            cur_rsp = (rsp_q.size() != 0) ? rsp_q[0] : 2'b10;
            chk("rnd_hsel1", HSEL_1, in1);
            chk("rnd_hsel2", HSEL_2, in2);
            chk("rnd_mux", muxSelect, exp_mux);
            chk("rnd_def", defaultSel, exp_def);
            chk("rnd_rdy", HREADYOUT_DEF, cur_rsp[1]);
            chk("rnd_resp", HRESP_DEF, cur_rsp[0]);
            chk("rnd_cnt", errCount, exp_cnt);
            if (r_ready) begin
                exp_mux = in2;
                exp_def = unm;
            end
            if (rsp_q.size() != 0) begin
                popped = rsp_q.pop_front();
                if (popped == 2'b01 && exp_cnt < 255) exp_cnt++;
            end
            if (cur_rsp[1] && unm && r_ready && r_trans[1]) begin
                rsp_q.push_back(2'b01);
                rsp_q.push_back(2'b11);
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
